// File: rtl/ramif_rr_arb.sv
// Round-robin arbiter multiplexing NPORT RAM masters onto a single RAM slave.
// Two states: IDLE (arbitrate) and BUSY (slave driven from the granted master).
// Optional build macro RAMIF_ARB_TIMEOUT_EN adds an err output and a BUSY
// watchdog that completes a stuck access with all-ones read data.
module ramif_rr_arb #(
    parameter int unsigned NPORT = 4,
    parameter int unsigned AW    = 14,
    parameter int unsigned DW    = 32,
    parameter int unsigned BW    = 8,
    parameter int unsigned TMO   = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NPORT-1:0]        m_ramen,
    input  logic [NPORT-1:0]        m_ramcs,
    input  logic [NPORT*AW-1:0]     m_ramaddr,
    input  logic [NPORT*(DW/BW)-1:0] m_ramwr,
    input  logic [NPORT*DW-1:0]     m_ramwdata,
    output logic [DW-1:0]           m_ramrdata,
    output logic [NPORT-1:0]        m_ramready,
    output logic                    s_ramen,
    output logic                    s_ramcs,
    output logic [AW-1:0]           s_ramaddr,
    output logic [DW/BW-1:0]        s_ramwr,
    output logic [DW-1:0]           s_ramwdata,
    input  logic [DW-1:0]           s_ramrdata,
    input  logic                    s_ramready,
`ifdef RAMIF_ARB_TIMEOUT_EN
    output logic                    err,
`endif
    output logic [NPORT-1:0]        grant
);

    localparam int unsigned WW = DW / BW;
    localparam int unsigned IW = $clog2(NPORT);

    // Elaboration-time parameter sanity checks.
    if (NPORT < 2 || NPORT > 8) begin : g_bad_nport
        $error("NPORT must be in 2..8");
    end
    if (TMO < 1) begin : g_bad_tmo
        $error("TMO must be at least 1");
    end

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e           state_q, state_d;
    logic [NPORT-1:0] grant_q, grant_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]    next_ptr;

    logic [NPORT-1:0] req;
    logic             pick_found;
    logic [IW-1:0]    pick_idx;
    logic [NPORT-1:0] pick_oh;

    logic [AW-1:0]    sel_addr;
    logic [WW-1:0]    sel_wr;
    logic [DW-1:0]    sel_wdata;
    logic             gnt_req;

`ifdef RAMIF_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TMO + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`endif

    assign req      = m_ramen & m_ramcs;
    assign grant    = grant_q;
    assign gnt_req  = |(grant_q & req);
    assign next_ptr = (32'(idx_q) == NPORT - 1) ? '0 : idx_q + 1'b1;

    // Pick the first requester at or after rr_ptr, wrapping past NPORT-1.
    always_comb begin : p_pick
        int unsigned j;
        logic [IW-1:0] jj;
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_oh    = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            j = 32'(rr_ptr_q) + i;
            if (j >= NPORT) j = j - NPORT;
            jj = IW'(j);
            if (!pick_found && req[jj]) begin
                pick_found  = 1'b1;
                pick_idx    = jj;
                pick_oh[jj] = 1'b1;
            end
        end
    end

    // Mux the granted master's request fields (grant_q is one-hot or zero).
    always_comb begin
        sel_addr  = '0;
        sel_wr    = '0;
        sel_wdata = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            if (grant_q[i]) begin
                sel_addr  = m_ramaddr[i*AW +: AW];
                sel_wr    = m_ramwr[i*WW +: WW];
                sel_wdata = m_ramwdata[i*DW +: DW];
            end
        end
    end

    // Next-state logic and all slave/master-side outputs.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        idx_d      = idx_q;
        rr_ptr_d   = rr_ptr_q;
        s_ramen    = 1'b0;
        s_ramcs    = 1'b0;
        s_ramaddr  = '0;
        s_ramwr    = '0;
        s_ramwdata = '0;
        m_ramready = '0;
        m_ramrdata = s_ramrdata;
`ifdef RAMIF_ARB_TIMEOUT_EN
        cnt_d      = cnt_q;
        err        = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                // s_ramready is deliberately ignored here.
                if (pick_found) begin
                    state_d = StBusy;
                    grant_d = pick_oh;
                    idx_d   = pick_idx;
`ifdef RAMIF_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            StBusy: begin
                s_ramaddr  = sel_addr;
                s_ramwr    = sel_wr;
                s_ramwdata = sel_wdata;
                s_ramen    = gnt_req;
                s_ramcs    = gnt_req;
                if (!gnt_req) begin
                    // Master abandoned the access: release without moving rr_ptr.
                    state_d = StIdle;
                    grant_d = '0;
                end else if (s_ramready) begin
                    m_ramready = grant_q;
                    rr_ptr_d   = next_ptr;
                    state_d    = StIdle;
                    grant_d    = '0;
`ifdef RAMIF_ARB_TIMEOUT_EN
                end else if (cnt_q == CW'(TMO)) begin
                    err        = 1'b1;
                    m_ramready = grant_q;
                    m_ramrdata = '1;
                    rr_ptr_d   = next_ptr;
                    state_d    = StIdle;
                    grant_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            grant_q  <= '0;
            idx_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

`ifdef RAMIF_ARB_TIMEOUT_EN
    // BUSY-cycle watchdog counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule
